alu_port_arbiter: RTL and testbench
===================================

// Module: alu_port_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for one shared multi-cycle execution unit (e.g. multdiv)
//   with 8 requesters. Drives the 3-bit select of the 8:1 32-bit operand/result mux and the
//   unit's start pulse, holds the grant until the unit reports done, and releases the grant on
//   a hung operation. Sits between the requesting pipeline ports and the shared unit's input mux.
// PARAMETERS
//   N_REQ    8   number of requesters; fixed at 8 to match the 8:1 mux (SEL_W = 3)
//   MAX_HOLD 15  WAIT cycles allowed before timeout; range 1..255, 8-bit hold counter
// PORTS
//   clock        in   1  single clock; all state updates on the rising edge
//   reset_n      in   1  asynchronous, active-low reset
//   req          in   8  req[i]=1: requester i wants the unit; level held until granted
//   op_done      in   1  unit finished current op; sampled only in WAIT
//   grant        out  8  one-hot grant, or all-zero; registered
//   sel          out  3  binary index of the granted requester, feeds the mux select; registered
//   unit_start   out  1  one-cycle start pulse to the unit, high only in ISSUE
//   busy         out  1  high in ISSUE and WAIT
//   timeout_err  out  1  one-cycle pulse when a hold times out
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, grant=0, sel=0, unit_start=0, busy=0,
//     timeout_err=0, rr_ptr=0, hold_cnt=0. Requester 0 has top priority after reset.
//     reset_n asserted mid-op aborts immediately; the unit is not notified.
//   Priority: the first set req bit found scanning rr_ptr, rr_ptr+1, ... mod 8 (7 wraps to 0).
//     On a grant to i, rr_ptr <= (i+1) mod 8.
//   FSM states: IDLE, ISSUE, WAIT.
//     IDLE : if |req, pick winner w; next cycle ISSUE with grant=1<<w, sel=w.
//            Else stay in IDLE.
//     ISSUE: exactly 1 cycle. unit_start=1, busy=1, hold_cnt<=0. Always goes to WAIT.
//            op_done is ignored here; the unit's minimum latency is 2 cycles.
//     WAIT : busy=1, grant/sel held, hold_cnt increments each cycle.
//       op_done=1 : if |req (other requesters, or the same one re-requesting), arbitrate with
//                   the updated rr_ptr and go to ISSUE next cycle with the new grant
//                   (back-to-back, no idle bubble). Else go to IDLE with grant=0.
//       op_done=0 and hold_cnt==MAX_HOLD-1 : timeout_err=1 next cycle, grant=0, to IDLE.
//       op_done and timeout in the same cycle: op_done wins, no timeout_err.
//   Grant latency: req rising in IDLE gives grant and unit_start 1 cycle later.
//     Minimum per-op occupancy is ISSUE + 1 WAIT cycle.
//   A granted requester dropping req during ISSUE/WAIT does not abort; the grant is held until
//     op_done or timeout.
//   When grant is zero, sel keeps its last value; consumers qualify with grant/busy.
//   Invariants: grant is never multi-hot; sel == index of grant whenever grant != 0;
//     unit_start implies state==ISSUE.
// TESTING
//   1. Reset: reset_n=0 with req=8'hFF -> grant=0, sel=0, busy=0. Release reset ->
//      grant=8'h01, sel=0, unit_start=1 one cycle later.
//   2. Round robin: req=8'hFF held, op_done 2 cycles after each start -> grant sequence
//      01,02,04,...,80,01 (wraps). ISSUE follows the done cycle with no IDLE bubble.
//   3. Single requester: req=8'h20 only -> sel=5. On done with req still high -> re-granted 5
//      immediately. With req low at done -> IDLE, grant=0.
//   4. Timeout: MAX_HOLD=4, grant bit 3, op_done never asserted -> after 4 WAIT cycles
//      timeout_err pulses once, grant=0, and the next pending req (bit 4) is granted.
//   5. Done vs timeout: op_done on the final WAIT cycle -> timeout_err stays 0, normal release.
//   6. Abort: reset_n pulsed low mid-WAIT for a partial cycle -> all outputs 0 immediately,
//      rr_ptr=0 afterwards; an op_done arriving later in IDLE is ignored.

Source files
------------

// File: rtl/alu_port_arbiter.sv
// Round-robin arbiter/sequencer for one shared multi-cycle unit; grant and unit_start 1 cycle after req in IDLE.
// Grant held until op_done or hold timeout; req is a level held by the requester until granted.
module alu_port_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     op_done,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] sel,
    output logic                     unit_start,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int SEL_W = $clog2(N_REQ);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   rr_ptr_nxt;
    logic [7:0]         hold_cnt;
    logic [7:0]         hold_cnt_nxt;
    logic               timeout_nxt;

    logic               win_vld;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   cand;

    // Scan from the farthest offset down so the requester closest to rr_ptr is assigned last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = rr_ptr + SEL_W'(k);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        sel_nxt      = sel;
        rr_ptr_nxt   = rr_ptr;
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    state_nxt  = S_ISSUE;
                    grant_nxt  = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    sel_nxt    = win_idx;
                    rr_ptr_nxt = win_idx + SEL_W'(1);
                end
            end

            S_ISSUE: begin
                hold_cnt_nxt = '0;
                state_nxt    = S_WAIT;
            end

            S_WAIT: begin
                // op_done takes precedence over an expiring hold in the same cycle.
                if (op_done) begin
                    if (win_vld) begin
                        state_nxt  = S_ISSUE;
                        grant_nxt  = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        sel_nxt    = win_idx;
                        rr_ptr_nxt = win_idx + SEL_W'(1);
                    end else begin
                        state_nxt = S_IDLE;
                        grant_nxt = '0;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = S_IDLE;
                    grant_nxt   = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            grant       <= '0;
            sel         <= '0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            sel         <= sel_nxt;
            rr_ptr      <= rr_ptr_nxt;
            hold_cnt    <= hold_cnt_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    assign unit_start = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Bench for alu_port_arbiter: scenario tasks with a queue of expected grant indices.
module tb_alu_port_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] req;
    logic       op_done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       unit_start;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    alu_port_arbiter #(.N_REQ(8), .MAX_HOLD(MAX_HOLD)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .op_done     (op_done),
        .grant       (grant),
        .sel         (sel),
        .unit_start  (unit_start),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 8'h00;
        op_done = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_start(input int limit, output int waited, output bit seen);
        waited = 0;
        seen   = 1'b0;
        while (waited < limit && !seen) begin
            if (unit_start === 1'b1) seen = 1'b1;
            else begin
                @(negedge clock);
                waited++;
            end
        end
    endtask

    task automatic test_reset();
        int idx;
        logic [7:0] eg;
        reset_n = 1'b0;
        req     = 8'hFF;
        op_done = 1'b0;
        exp_q.push_back(0);
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (grant !== 8'h00) $display("FAIL reset_grant: got %h expected 00", grant); else n_pass++;
        n_checks++;
        if (sel !== 3'd0) $display("FAIL reset_sel: got %0d expected 0", sel); else n_pass++;
        n_checks++;
        if ({busy, unit_start, timeout_err} !== 3'b000)
            $display("FAIL reset_flags: got busy/start/tmo=%b expected 000", {busy, unit_start, timeout_err});
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clock);
        idx = exp_q.pop_front();
        eg  = 8'h01 << idx;
        n_checks++;
        if (unit_start !== 1'b1) $display("FAIL reset_first_start: got %b expected 1", unit_start); else n_pass++;
        n_checks++;
        if (grant !== eg || sel !== 3'(idx))
            $display("FAIL reset_first_grant: got grant=%h sel=%0d expected grant=%h sel=%0d", grant, sel, eg, idx);
        else n_pass++;
        req = 8'h00;
    endtask

    task automatic test_round_robin();
        int waited;
        bit seen;
        int idx;
        logic [7:0] eg;
        do_reset();
        for (int k = 0; k <= 8; k++) exp_q.push_back(k % 8);
        req = 8'hFF;
        @(negedge clock);
        for (int k = 0; k <= 8; k++) begin
            wait_start(10, waited, seen);
            idx = exp_q.pop_front();
            eg  = 8'h01 << idx;
            n_checks++;
            if (!seen || waited != 0)
                $display("FAIL rr_no_bubble_%0d: got start after %0d cycles (seen=%0b) expected 0", k, waited, seen);
            else n_pass++;
            n_checks++;
            if (grant !== eg || sel !== 3'(idx))
                $display("FAIL rr_grant_%0d: got grant=%h sel=%0d expected grant=%h sel=%0d", k, grant, sel, eg, idx);
            else n_pass++;
            @(negedge clock);
            if (k == 0) begin
                n_checks++;
                if (busy !== 1'b1 || unit_start !== 1'b0)
                    $display("FAIL rr_wait_flags: got busy=%b start=%b expected busy=1 start=0", busy, unit_start);
                else n_pass++;
            end
            @(negedge clock);
            op_done = 1'b1;
            @(negedge clock);
            op_done = 1'b0;
        end
        req = 8'h00;
    endtask

    task automatic test_single();
        int idx;
        do_reset();
        exp_q.push_back(5);
        exp_q.push_back(5);
        req = 8'h20;
        @(negedge clock);
        idx = exp_q.pop_front();
        n_checks++;
        if (unit_start !== 1'b1 || grant !== (8'h01 << idx) || sel !== 3'(idx))
            $display("FAIL single_first: got start=%b grant=%h sel=%0d expected start=1 grant=20 sel=%0d", unit_start, grant, sel, idx);
        else n_pass++;
        @(negedge clock);
        @(negedge clock);
        op_done = 1'b1;
        @(negedge clock);
        op_done = 1'b0;
        idx = exp_q.pop_front();
        n_checks++;
        if (unit_start !== 1'b1 || grant !== (8'h01 << idx) || sel !== 3'(idx))
            $display("FAIL single_regrant: got start=%b grant=%h sel=%0d expected start=1 grant=20 sel=%0d", unit_start, grant, sel, idx);
        else n_pass++;
        @(negedge clock);
        req = 8'h00;
        @(negedge clock);
        n_checks++;
        if (grant !== 8'h20 || busy !== 1'b1)
            $display("FAIL single_hold_after_drop: got grant=%h busy=%b expected grant=20 busy=1", grant, busy);
        else n_pass++;
        op_done = 1'b1;
        @(negedge clock);
        op_done = 1'b0;
        n_checks++;
        if (grant !== 8'h00 || busy !== 1'b0)
            $display("FAIL single_release: got grant=%h busy=%b expected grant=00 busy=0", grant, busy);
        else n_pass++;
        n_checks++;
        if (sel !== 3'd5) $display("FAIL single_sel_kept: got %0d expected 5", sel); else n_pass++;
    endtask

    task automatic test_timeout();
        int idx;
        do_reset();
        exp_q.push_back(3);
        exp_q.push_back(4);
        req = 8'h18;
        @(negedge clock);
        idx = exp_q.pop_front();
        n_checks++;
        if (unit_start !== 1'b1 || grant !== (8'h01 << idx) || sel !== 3'(idx))
            $display("FAIL tmo_first: got start=%b grant=%h sel=%0d expected start=1 sel=%0d", unit_start, grant, sel, idx);
        else n_pass++;
        req = 8'h10;
        for (int c = 0; c < MAX_HOLD; c++) begin
            @(negedge clock);
            n_checks++;
            if (timeout_err !== 1'b0 || grant !== 8'h08 || busy !== 1'b1)
                $display("FAIL tmo_hold_%0d: got tmo=%b grant=%h busy=%b expected tmo=0 grant=08 busy=1", c, timeout_err, grant, busy);
            else n_pass++;
        end
        @(negedge clock);
        n_checks++;
        if (timeout_err !== 1'b1 || grant !== 8'h00 || busy !== 1'b0)
            $display("FAIL tmo_pulse: got tmo=%b grant=%h busy=%b expected tmo=1 grant=00 busy=0", timeout_err, grant, busy);
        else n_pass++;
        @(negedge clock);
        idx = exp_q.pop_front();
        n_checks++;
        if (unit_start !== 1'b1 || grant !== (8'h01 << idx) || sel !== 3'(idx))
            $display("FAIL tmo_next: got start=%b grant=%h sel=%0d expected start=1 sel=%0d", unit_start, grant, sel, idx);
        else n_pass++;
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL tmo_single_pulse: got %b expected 0", timeout_err); else n_pass++;
        req = 8'h00;
    endtask

    task automatic test_done_vs_timeout();
        int idx;
        do_reset();
        exp_q.push_back(1);
        req = 8'h02;
        @(negedge clock);
        idx = exp_q.pop_front();
        n_checks++;
        if (unit_start !== 1'b1 || sel !== 3'(idx))
            $display("FAIL dvt_first: got start=%b sel=%0d expected start=1 sel=%0d", unit_start, sel, idx);
        else n_pass++;
        req = 8'h00;
        for (int c = 0; c < MAX_HOLD; c++) @(negedge clock);
        op_done = 1'b1;
        @(negedge clock);
        op_done = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0 || grant !== 8'h00 || busy !== 1'b0)
            $display("FAIL dvt_release: got tmo=%b grant=%h busy=%b expected tmo=0 grant=00 busy=0", timeout_err, grant, busy);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL dvt_no_late_pulse: got %b expected 0", timeout_err); else n_pass++;
    endtask

    task automatic test_abort();
        int idx;
        do_reset();
        req = 8'h40;
        @(negedge clock);
        n_checks++;
        if (unit_start !== 1'b1 || sel !== 3'd6)
            $display("FAIL abort_first: got start=%b sel=%0d expected start=1 sel=6", unit_start, sel);
        else n_pass++;
        @(negedge clock);
        req = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== 8'h00 || sel !== 3'd0 || {busy, unit_start, timeout_err} !== 3'b000)
            $display("FAIL abort_outputs: got grant=%h sel=%0d flags=%b expected all zero", grant, sel, {busy, unit_start, timeout_err});
        else n_pass++;
        #1 reset_n = 1'b1;
        @(negedge clock);
        op_done = 1'b1;
        @(negedge clock);
        op_done = 1'b0;
        n_checks++;
        if (grant !== 8'h00 || busy !== 1'b0 || unit_start !== 1'b0)
            $display("FAIL abort_done_ignored: got grant=%h busy=%b start=%b expected 00/0/0", grant, busy, unit_start);
        else n_pass++;
        exp_q.push_back(0);
        req = 8'hFF;
        @(negedge clock);
        idx = exp_q.pop_front();
        n_checks++;
        if (unit_start !== 1'b1 || grant !== (8'h01 << idx) || sel !== 3'(idx))
            $display("FAIL abort_rr_ptr: got start=%b grant=%h sel=%0d expected start=1 grant=01 sel=%0d", unit_start, grant, sel, idx);
        else n_pass++;
        req = 8'h00;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 8'h00;
        op_done = 1'b0;
        @(negedge clock);
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_done_vs_timeout();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
